// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider scheduler.
package clk_div_pkg;

  localparam int unsigned CLAMP_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  // A half-period of zero would stall the divider; treat it as one cycle.
  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] x);
    return (x == '0) ? CLAMP_W'(1) : x;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             vld_c,
  output logic [N_REQ-1:0] oh_c,
  output logic [IDX_W-1:0] idx_c
);

  always_comb begin
    int unsigned cand;
    logic        found;
    cand  = 0;
    found = 1'b0;
    vld_c = 1'b0;
    oh_c  = '0;
    idx_c = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found               = 1'b1;
        vld_c               = 1'b1;
        idx_c               = IDX_W'(cand);
        oh_c[IDX_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Round-robin scheduler handing one programmable clock divider to N requesters,
// with clk_out always starting and ending low so ownership changes are glitch-free.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter  int unsigned N_REQ  = 2,
  parameter  int unsigned DIV_W  = 8,
  parameter  int unsigned NPER_W = 8,
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_in,
  input  logic                    aclr_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DIV_W-1:0]  div,
  input  logic [N_REQ*NPER_W-1:0] nper,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    clk_out,
  output logic                    tick,
  output logic [N_REQ-1:0]        done
);

  sched_state_t      state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              busy_q, busy_d;
  logic              clk_out_q, clk_out_d;
  logic              tick_q, tick_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  hcnt_q, hcnt_d;
  logic [NPER_W-1:0] pleft_q, pleft_d;

  logic [DIV_W-1:0]  div_arr  [N_REQ];
  logic [NPER_W-1:0] nper_arr [N_REQ];
  logic              pick_vld;
  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic [DIV_W-1:0]  pick_div;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
    return (32'(i) == N_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  // Unpack the flat per-requester configuration buses.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      div_arr[i]  = div[i*DIV_W +: DIV_W];
      nper_arr[i] = nper[i*NPER_W +: NPER_W];
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .ptr   (rr_q),
    .vld_c (pick_vld),
    .oh_c  (pick_oh),
    .idx_c (pick_idx)
  );

  assign pick_div = DIV_W'(clamp_div(CLAMP_W'(div_arr[pick_idx])));

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    busy_d    = busy_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    rr_d      = rr_q;
    owner_d   = owner_q;
    div_d     = div_q;
    hcnt_d    = hcnt_q;
    pleft_d   = pleft_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d   = pick_idx;
          div_d     = pick_div;
          pleft_d   = nper_arr[pick_idx];
          hcnt_d    = pick_div - DIV_W'(1);
          clk_out_d = 1'b0;
          busy_d    = 1'b1;
          if (nper_arr[pick_idx] == '0) begin
            state_d = S_DONE;
            grant_d = '0;
            done_d  = pick_oh;
            rr_d    = rr_next(pick_idx);
          end else begin
            state_d = S_RUN;
            grant_d = pick_oh;
          end
        end
      end

      S_RUN: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - DIV_W'(1);
        end else begin
          hcnt_d    = div_q - DIV_W'(1);
          clk_out_d = ~clk_out_q;
          if (!clk_out_q) begin
            tick_d = 1'b1;
          end else begin
            // Falling edge closes a period; only here may the burst end or abort.
            pleft_d = pleft_q - NPER_W'(1);
            if (pleft_q == NPER_W'(1) || !req[owner_q]) begin
              state_d = S_DONE;
              grant_d = '0;
              done_d  = grant_q;
              rr_d    = rr_next(owner_q);
            end
          end
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        busy_d    = 1'b0;
        clk_out_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        busy_d    = 1'b0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      rr_q      <= '0;
      owner_q   <= '0;
      div_q     <= '0;
      hcnt_q    <= '0;
      pleft_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      pleft_q   <= pleft_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: burst-level reference model, per-cycle compare, directed and random stimulus.
module tb_clk_div_sched;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk_in = 1'b0;
  logic          aclr_n = 1'b0;
  logic [N-1:0]  req    = '0;
  logic [N*DW-1:0] div  = '0;
  logic [N*PW-1:0] nper = '0;
  logic [N-1:0]  grant;
  logic          busy;
  logic          clk_out;
  logic          tick;
  logic [N-1:0]  done;

  clk_div_sched #(.N_REQ(N), .DIV_W(DW), .NPER_W(PW)) dut (
    .clk_in  (clk_in),
    .aclr_n  (aclr_n),
    .req     (req),
    .div     (div),
    .nper    (nper),
    .grant   (grant),
    .busy    (busy),
    .clk_out (clk_out),
    .tick    (tick),
    .done    (done)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a burst is described by owner, half-period d, period count p
  // and k = cycles since the burst started; outputs follow from arithmetic on k.
  int m_mode = 0;  // 0 idle, 1 run, 2 done
  int m_owner = 0, m_d = 1, m_p = 0, m_k = 0, m_rr = 0, m_w = -1, m_c = 0;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic e_busy = 1'b0, e_clk = 1'b0, e_tick = 1'b0;

  always @(posedge clk_in or negedge aclr_n) begin
    if (!aclr_n) begin
      m_mode = 0; m_rr = 0; m_k = 0;
      e_grant = '0; e_done = '0; e_busy = 1'b0; e_clk = 1'b0; e_tick = 1'b0;
    end else begin
      e_tick = 1'b0;
      e_done = '0;
      case (m_mode)
        0: begin
          m_w = -1;
          for (int off = 0; off < N; off++) begin
            m_c = (m_rr + off) % N;
            if (m_w < 0 && req[1'(m_c)]) m_w = m_c;
          end
          if (m_w >= 0) begin
            m_owner = m_w;
            m_d = int'(div[m_w*DW +: DW]);
            if (m_d == 0) m_d = 1;
            m_p = int'(nper[m_w*PW +: PW]);
            e_busy = 1'b1;
            e_clk  = 1'b0;
            if (m_p == 0) begin
              m_mode  = 2;
              e_grant = '0;
              e_done  = N'(1 << m_w);
              m_rr    = (m_w + 1) % N;
            end else begin
              m_mode  = 1;
              m_k     = 0;
              e_grant = N'(1 << m_w);
            end
          end
        end
        1: begin
          if ((m_k % (2*m_d)) == 2*m_d - 1 &&
              (((m_k + 1) / (2*m_d)) == m_p || !req[1'(m_owner)])) begin
            m_mode  = 2;
            e_grant = '0;
            e_done  = N'(1 << m_owner);
            e_clk   = 1'b0;
            m_rr    = (m_owner + 1) % N;
          end else begin
            m_k++;
            e_clk  = ((m_k / m_d) % 2) == 1;
            e_tick = (m_k % (2*m_d)) == m_d;
          end
        end
        default: begin
          m_mode = 0; e_grant = '0; e_busy = 1'b0; e_clk = 1'b0;
        end
      endcase
    end
  end

  // Per-cycle compare against the model plus structural invariants.
  bit en = 1'b0;
  logic prev_clk = 1'b0;
  int tick_cnt = 0, high_cnt = 0, g0_cnt = 0, g1_cnt = 0;

  always @(posedge clk_in) begin
    #1;
    if (en) begin
      chk("grant",   32'(grant),   32'(e_grant));
      chk("done",    32'(done),    32'(e_done));
      chk("busy",    32'(busy),    32'(e_busy));
      chk("clk_out", 32'(clk_out), 32'(e_clk));
      chk("tick",    32'(tick),    32'(e_tick));
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (tick) chk("tick_on_rise", {30'd0, prev_clk, clk_out}, 32'b01);
      if (grant == '0) chk("clk_low_when_idle", 32'(clk_out), 32'd0);
      tick_cnt += int'(tick);
      high_cnt += int'(clk_out);
      g0_cnt   += int'(grant[0]);
      g1_cnt   += int'(grant[1]);
    end
    prev_clk = clk_out;
  end

  task automatic wait_done_any(input string nm, input int budget, output logic [N-1:0] got);
    bit seen;
    seen = 1'b0;
    got  = '0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk_in); #1;
      if (done != '0) begin seen = 1'b1; got = done; end
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    @(negedge clk_in);
  endtask

  task automatic wait_tick(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk_in); #1;
      if (tick) seen = 1'b1;
    end
    chk({nm, "_tick_seen"}, 32'(seen), 32'd1);
    @(negedge clk_in);
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    aclr_n = 1'b0;
    @(negedge clk_in);
    aclr_n = 1'b1;
  endtask

  int s_tick, s_high, s_g0, s_g1;
  task automatic snap();
    s_tick = tick_cnt; s_high = high_cnt; s_g0 = g0_cnt; s_g1 = g1_cnt;
  endtask

  logic [N-1:0] got;
  logic [N-1:0] seq [4];

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_clk",   32'(clk_out), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    aclr_n = 1'b1;
    en = 1'b1;
    @(negedge clk_in);

    // 1: single burst, div=3, nper=2
    div[0 +: DW] = 8'd3; nper[0 +: PW] = 8'd2;
    div[DW +: DW] = 8'd7; nper[PW +: PW] = 8'd9;
    snap();
    req = 2'b01;
    @(posedge clk_in); #1;
    chk("t1_grant_next", 32'(grant), 32'b01);
    wait_done_any("t1", 40, got);
    req = 2'b00;
    chk("t1_done_owner", 32'(got), 32'b01);
    chk("t1_ticks", 32'(tick_cnt - s_tick), 32'd2);
    chk("t1_high",  32'(high_cnt - s_high), 32'd6);
    chk("t1_run",   32'(g0_cnt - s_g0),     32'd12);

    // 2: both held, div=2 nper=1, from rr=0
    pulse_reset();
    div = {8'd2, 8'd2}; nper = {8'd1, 8'd1};
    snap();
    req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_done_any("t2", 20, got);
      seq[b] = got;
    end
    req = 2'b00;
    chk("t2_seq0", 32'(seq[0]), 32'b01);
    chk("t2_seq1", 32'(seq[1]), 32'b10);
    chk("t2_seq2", 32'(seq[2]), 32'b01);
    chk("t2_seq3", 32'(seq[3]), 32'b10);
    chk("t2_high", 32'(high_cnt - s_high), 32'd8);
    chk("t2_run0", 32'(g0_cnt - s_g0), 32'd8);

    // 3: abort during first high phase of a 5-period burst
    @(negedge clk_in);
    div[0 +: DW] = 8'd4; nper[0 +: PW] = 8'd5;
    snap();
    req = 2'b01;
    wait_tick("t3", 20);
    req = 2'b00;
    wait_done_any("t3", 20, got);
    chk("t3_done_owner", 32'(got), 32'b01);
    chk("t3_ticks", 32'(tick_cnt - s_tick), 32'd1);
    chk("t3_high",  32'(high_cnt - s_high), 32'd4);
    chk("t3_run",   32'(g0_cnt - s_g0),     32'd8);

    // 4: div=0 behaves as 1, then nper=0 ends immediately
    @(negedge clk_in);
    div[0 +: DW] = 8'd0; nper[0 +: PW] = 8'd1;
    snap();
    req = 2'b01;
    wait_done_any("t4a", 20, got);
    chk("t4a_ticks", 32'(tick_cnt - s_tick), 32'd1);
    chk("t4a_high",  32'(high_cnt - s_high), 32'd1);
    chk("t4a_run",   32'(g0_cnt - s_g0),     32'd2);
    nper[0 +: PW] = 8'd0;
    snap();
    wait_done_any("t4b", 6, got);
    req = 2'b00;
    chk("t4b_done_owner", 32'(got), 32'b01);
    chk("t4b_ticks", 32'(tick_cnt - s_tick), 32'd0);
    chk("t4b_run",   32'(g0_cnt - s_g0),     32'd0);

    // 5: reset while clk_out is high, then re-grant from rr=0
    @(negedge clk_in);
    div = {8'd5, 8'd2}; nper = {8'd3, 8'd1};
    req = 2'b11;
    wait_tick("t5", 20);
    chk("t5_owner_before", 32'(grant), 32'b10);
    aclr_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant),   32'd0);
    chk("t5_rst_clk",   32'(clk_out), 32'd0);
    chk("t5_rst_busy",  32'(busy),    32'd0);
    chk("t5_rst_done",  32'(done),    32'd0);
    @(negedge clk_in);
    aclr_n = 1'b1;
    @(posedge clk_in); #1;
    chk("t5_regrant", 32'(grant), 32'b01);
    wait_done_any("t5a", 20, got);
    chk("t5a_owner", 32'(got), 32'b01);
    req[0] = 1'b0;
    wait_done_any("t5b", 60, got);
    chk("t5b_owner", 32'(got), 32'b10);
    req = 2'b00;

    // Random traffic with aborts, config churn and occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_in);
      if (!aclr_n) aclr_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) aclr_n = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            div[i*DW +: DW]  = 8'($urandom_range(0, 6));
            nper[i*PW +: PW] = 8'($urandom_range(0, 5));
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) begin
          div[i*DW +: DW]  = 8'($urandom_range(0, 6));
          nper[i*PW +: PW] = 8'($urandom_range(0, 5));
        end
      end
    end
    aclr_n = 1'b1;
    req = '0;
    repeat (100) @(negedge clk_in);
    chk("final_idle_grant", 32'(grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
